// File: rtl/w450_mmio.sv
// w450_mmio: memory-mapped I/O stage between the core's write port / read
// port 1 and the memory array. Decodes a 16-byte I/O window holding a
// transmit FIFO data port, a status register and a sticky halt register.
module w450_mmio #(
  parameter int unsigned    n       = 8,
  parameter int unsigned    DEPTH   = 4,
  parameter logic [n-1:0]   IO_BASE = 8'hF0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [n-1:0] cpu_wr_data,
  input  logic [n-1:0] cpu_wr_addr,
  input  logic         cpu_wr_en,
  input  logic [n-1:0] cpu_rd_addr1,
  output logic [n-1:0] cpu_rd_data1,
  output logic [n-1:0] mem_wr_data,
  output logic [n-1:0] mem_wr_addr,
  output logic         mem_wr_en,
  output logic [n-1:0] mem_rd_addr1,
  input  logic [n-1:0] mem_rd_data1,
  output logic [n-1:0] tx_data,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic         halted
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  typedef logic [n-1:0] word_t;

  // Window offsets of the decoded registers
  localparam word_t OFF_TXDATA = word_t'(0);
  localparam word_t OFF_STATUS = word_t'(1);
  localparam word_t OFF_HALT   = word_t'(15);
  localparam word_t WIN_SIZE   = word_t'(16);

  // FIFO storage and bookkeeping
  word_t          r_store [DEPTH];
  logic [AW-1:0]  r_head;
  logic [AW-1:0]  r_tail;
  logic [CW-1:0]  r_count;
  logic           r_ovf;
  logic           r_halted;

  // Decode and handshake wires
  word_t          w_wr_off;
  word_t          w_rd_off;
  logic           w_wr_win;
  logic           w_rd_win;
  logic           w_wr_ok;
  logic           w_wr_tx;
  logic           w_wr_status;
  logic           w_wr_halt;
  logic           w_full;
  logic           w_empty;
  logic           w_pop;
  logic           w_push;
  logic           w_drop;
  logic [7:0]     w_status;

  // Address decode for both the write port and read port 1
  always_comb begin
    w_wr_off    = cpu_wr_addr - IO_BASE;
    w_rd_off    = cpu_rd_addr1 - IO_BASE;
    w_wr_win    = (cpu_wr_addr >= IO_BASE) && (w_wr_off < WIN_SIZE);
    w_rd_win    = (cpu_rd_addr1 >= IO_BASE) && (w_rd_off < WIN_SIZE);
    // A halted core may not write anywhere, including the I/O registers
    w_wr_ok     = cpu_wr_en && !r_halted;
    w_wr_tx     = w_wr_ok && w_wr_win && (w_wr_off == OFF_TXDATA);
    w_wr_status = w_wr_ok && w_wr_win && (w_wr_off == OFF_STATUS);
    w_wr_halt   = w_wr_ok && w_wr_win && (w_wr_off == OFF_HALT);
  end

  // FIFO handshake: a pop on a full FIFO frees the slot for a same-edge push
  always_comb begin
    w_full   = (r_count == CW'(DEPTH));
    w_empty  = (r_count == '0);
    w_pop    = !w_empty && tx_ready;
    w_push   = w_wr_tx && (!w_full || w_pop);
    w_drop   = w_wr_tx && w_full && !w_pop;
    w_status = {r_halted, 4'(r_count), r_ovf, w_empty, w_full};
  end

  // Write routing: outside the window and the halt register reach memory
  always_comb begin
    mem_wr_data = cpu_wr_data;
    mem_wr_addr = cpu_wr_addr;
    mem_wr_en   = w_wr_ok && (!w_wr_win || (w_wr_off == OFF_HALT));
  end

  // Read port 1 mux: status register, zero for other I/O slots, else memory
  always_comb begin
    mem_rd_addr1 = cpu_rd_addr1;
    cpu_rd_data1 = mem_rd_data1;
    if (w_rd_win) begin
      if (w_rd_off == OFF_STATUS) begin
        cpu_rd_data1 = word_t'(w_status);
      end else if (w_rd_off != OFF_HALT) begin
        cpu_rd_data1 = '0;
      end
    end
  end

  // FIFO data storage; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_store[r_tail] <= cpu_wr_data;
    end
  end

  // FIFO pointers and occupancy count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_pop) begin
        r_head <= r_head + AW'(1);
      end
      if (w_push) begin
        r_tail <= r_tail + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky overflow (cleared by any STATUS write) and sticky halt
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ovf    <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (w_wr_status) begin
        r_ovf <= 1'b0;
      end
      if (w_wr_halt && (cpu_wr_data == word_t'(1))) begin
        r_halted <= 1'b1;
      end
    end
  end

  // Transmit side and halt flag outputs come straight from registers
  always_comb begin
    tx_data  = r_store[r_head];
    tx_valid = !w_empty;
    halted   = r_halted;
  end

endmodule

// File: tb/tb_w450_mmio.sv
// Bench for w450_mmio: queue-based reference model checked every cycle,
// plus directed literal checks from hand-worked scenarios.
module tb_w450_mmio;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] wd, wa, ra, mrd;
  logic       we, txr;
  logic [7:0] cpu_rd_data1, mem_wr_data, mem_wr_addr, mem_rd_addr1, tx_data;
  logic       mem_wr_en, tx_valid, halted;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [7:0] q[$];
  bit         m_ovf = 1'b0;
  bit         m_hlt = 1'b0;

  w450_mmio #(.n(8), .DEPTH(4), .IO_BASE(8'hF0)) dut (
    .clk(clk), .reset(reset),
    .cpu_wr_data(wd), .cpu_wr_addr(wa), .cpu_wr_en(we),
    .cpu_rd_addr1(ra), .cpu_rd_data1(cpu_rd_data1),
    .mem_wr_data(mem_wr_data), .mem_wr_addr(mem_wr_addr), .mem_wr_en(mem_wr_en),
    .mem_rd_addr1(mem_rd_addr1), .mem_rd_data1(mrd),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(txr),
    .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] m_status();
    return {m_hlt, 4'(q.size()), m_ovf, q.size() == 0, q.size() == 4};
  endfunction

  function automatic logic exp_wr_en();
    return we && !m_hlt && ((wa < 8'hF0) || (wa == 8'hFF));
  endfunction

  function automatic logic [7:0] exp_rd();
    if (ra == 8'hF1) return m_status();
    if (ra >= 8'hF0 && ra <= 8'hFE) return 8'h00;
    return mrd;
  endfunction

  // Model update at each edge: pop, then push/drop, clear, halt
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
      m_ovf = 1'b0;
      m_hlt = 1'b0;
    end else begin
      bit pop, was_full;
      pop      = (q.size() != 0) && txr;
      was_full = (q.size() == 4);
      if (pop) void'(q.pop_front());
      if (we && !m_hlt) begin
        if (wa == 8'hF0) begin
          if (!was_full || pop) q.push_back(wd);
          else m_ovf = 1'b1;
        end else if (wa == 8'hF1) begin
          m_ovf = 1'b0;
        end else if (wa == 8'hFF && wd == 8'h01) begin
          m_hlt = 1'b1;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    chk("mem_wr_en", 8'(mem_wr_en), 8'(exp_wr_en()));
    if (exp_wr_en()) begin
      chk("mem_wr_addr", mem_wr_addr, wa);
      chk("mem_wr_data", mem_wr_data, wd);
    end
    chk("mem_rd_addr1", mem_rd_addr1, ra);
    chk("cpu_rd_data1", cpu_rd_data1, exp_rd());
    chk("tx_valid", 8'(tx_valid), 8'(q.size() != 0));
    if (q.size() != 0) chk("tx_data", tx_data, q[0]);
    chk("halted", 8'(halted), 8'(m_hlt));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    we = 1'b1; wa = a; wd = d;
    tick();
    we = 1'b0;
  endtask

  initial begin
    logic [7:0] seq [4];
    reset = 1'b1; we = 1'b0; wa = '0; wd = '0; ra = '0; mrd = '0; txr = 1'b0;
    #2;
    chk("rst_tx_valid", 8'(tx_valid), 8'h00);
    chk("rst_halted", 8'(halted), 8'h00);
    ra = 8'hF1; #1;
    chk("rst_status", cpu_rd_data1, 8'h02);
    tick(); tick();
    reset = 1'b0;

    // Pass-through write and read
    we = 1'b1; wa = 8'h20; wd = 8'h10; ra = 8'h20; mrd = 8'h5A; #1;
    chk("pt_wr_en", 8'(mem_wr_en), 8'h01);
    chk("pt_wr_addr", mem_wr_addr, 8'h20);
    chk("pt_wr_data", mem_wr_data, 8'h10);
    chk("pt_rd", cpu_rd_data1, 8'h5A);
    tick(); we = 1'b0;

    // FIFO ordering
    txr = 1'b0;
    wr(8'hF0, 8'hA1); wr(8'hF0, 8'hA2); wr(8'hF0, 8'hA3);
    ra = 8'hF1; #1;
    chk("fifo3_status", cpu_rd_data1, 8'h18);
    txr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("fifo_order", tx_data, 8'hA1 + 8'(i));
      tick();
    end
    chk("fifo_empty_valid", 8'(tx_valid), 8'h00);
    chk("fifo_empty_status", cpu_rd_data1, 8'h02);
    txr = 1'b0;

    // Overflow, reserved reads, status clear, drain
    for (int i = 0; i < 5; i++) wr(8'hF0, 8'hB0 + 8'(i));
    #1;
    chk("ovf_status", cpu_rd_data1, 8'h25);
    ra = 8'hF0; #1; chk("rd_txdata_zero", cpu_rd_data1, 8'h00);
    ra = 8'hF5; #1; chk("rd_reserved_zero", cpu_rd_data1, 8'h00);
    ra = 8'hFF; mrd = 8'hC3; #1; chk("rd_halt_mem", cpu_rd_data1, 8'hC3);
    wr(8'hF1, 8'h00);
    ra = 8'hF1; #1;
    chk("ovf_clear_status", cpu_rd_data1, 8'h21);
    txr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("ovf_drain", tx_data, 8'hB0 + 8'(i));
      tick();
    end
    chk("ovf_drain_done", 8'(tx_valid), 8'h00);
    txr = 1'b0;

    // Full FIFO with simultaneous push and pop
    for (int i = 0; i < 4; i++) wr(8'hF0, 8'hC0 + 8'(i));
    chk("full_status", cpu_rd_data1, 8'h21);
    txr = 1'b1;
    wr(8'hF0, 8'h55);
    chk("full_pushpop_status", cpu_rd_data1, 8'h21);
    seq[0] = 8'hC1; seq[1] = 8'hC2; seq[2] = 8'hC3; seq[3] = 8'h55;
    for (int i = 0; i < 4; i++) begin
      chk("full_drain", tx_data, seq[i]);
      tick();
    end
    chk("full_drain_done", 8'(tx_valid), 8'h00);
    txr = 1'b0;

    // Halt behaviour
    wr(8'hF0, 8'h77);
    wr(8'hFF, 8'h02);
    chk("no_halt_on_02", 8'(halted), 8'h00);
    we = 1'b1; wa = 8'hFF; wd = 8'h01; #1;
    chk("halt_wr_en", 8'(mem_wr_en), 8'h01);
    tick(); we = 1'b0;
    chk("halt_set", 8'(halted), 8'h01);
    we = 1'b1; wa = 8'h20; wd = 8'h33; #1;
    chk("halt_block_mem", 8'(mem_wr_en), 8'h00);
    tick(); we = 1'b0;
    wr(8'hF0, 8'h99);
    ra = 8'hF1; #1;
    chk("halt_status", cpu_rd_data1, 8'h88);
    txr = 1'b1;
    chk("halt_drain_data", tx_data, 8'h77);
    tick();
    chk("halt_drain_done", 8'(tx_valid), 8'h00);
    chk("halt_empty_status", cpu_rd_data1, 8'h82);
    txr = 1'b0;

    // Synchronous-looking reset pulse, then asynchronous mid-cycle reset
    reset = 1'b1; tick(); reset = 1'b0; #1;
    chk("post_reset_status", cpu_rd_data1, 8'h02);
    wr(8'hF0, 8'h88); wr(8'hF0, 8'h89); wr(8'hFF, 8'h01);
    #1;
    chk("pre_async_status", cpu_rd_data1, 8'h90);
    #1; reset = 1'b1;
    #1;
    chk("async_tx_valid", 8'(tx_valid), 8'h00);
    chk("async_halted", 8'(halted), 8'h00);
    #2; reset = 1'b0;
    ra = 8'hF1; #1;
    chk("async_status", cpu_rd_data1, 8'h02);
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/w450_mmio.md
# w450_mmio

Memory-mapped I/O stage between the w450 core's write port and read port 1 and the `mem` array. Ordinary addresses pass straight through to memory. Writes into the I/O window are intercepted and feed a small transmit FIFO that drains over a valid/ready output. The block also captures the halt write and serves a status register on read port 1. Read port 2 connects directly from core to memory and does not pass through this block.

## Interface
Parameters:
- n, 8, data and address width
- DEPTH, 4, TX FIFO entries; power of two, 2..8
- IO_BASE, 8'hF0, base of the 16-byte I/O window (IO_BASE..IO_BASE+15)

Ports:
- clk  in  1  core clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- cpu_wr_data  in  n  write data from core
- cpu_wr_addr  in  n  write address from core
- cpu_wr_en  in  1  write strobe from core
- cpu_rd_addr1  in  n  read port 1 address from core
- cpu_rd_data1  out  n  read port 1 data to core
- mem_wr_data  out  n  write data to memory
- mem_wr_addr  out  n  write address to memory
- mem_wr_en  out  1  write strobe to memory
- mem_rd_addr1  out  n  read port 1 address to memory (= cpu_rd_addr1)
- mem_rd_data1  in  n  read port 1 data from memory
- tx_data  out  n  FIFO head byte
- tx_valid  out  1  FIFO non-empty
- tx_ready  in  1  consumer accepts head
- halted  out  1  sticky halt flag

## Operation
- Address map:
  - IO_BASE+0 is TXDATA, write-only.
  - IO_BASE+1 is STATUS: read; a write clears the overflow bit.
  - IO_BASE+2..+14 are reserved: writes are discarded and reads return 0.
  - IO_BASE+15 (8'hFF) is HALT.
- Write routing, all combinational:
  - Addresses outside the window: mem_wr_* = cpu_wr_*.
  - IO_BASE..+14: mem_wr_en=0.
  - HALT address: forwarded to memory unchanged and also decoded locally.
- TXDATA write with FIFO not full: push cpu_wr_data at the tail.
- TXDATA write with FIFO full: data dropped, overflow set (sticky).
- Pop: tx_valid && tx_ready at a rising edge advances the head.
- STATUS format:
  - bit0 full
  - bit1 empty
  - bit2 overflow
  - bits[6:3] count (0..DEPTH)
  - bit7 halted
- Read mux, combinational: cpu_rd_data1 is STATUS when cpu_rd_addr1==IO_BASE+1, 0 for the TXDATA and reserved addresses, and mem_rd_data1 otherwise.
- HALT: a write of 8'h01 to IO_BASE+15 sets halted. Other data values have no local effect.
- Once halted=1:
  - All further core writes are blocked: mem_wr_en=0 and no FIFO pushes.
  - The FIFO continues to drain.
- Pointers: head and tail are log2(DEPTH) bits and wrap modulo DEPTH. count is a separate register of log2(DEPTH)+1 bits.

## Timing
- Reset values:
  - count=0, head=0, tail=0, overflow=0, halted=0.
  - tx_valid=0; tx_data is undefined but is driven from the storage at head.
  - mem_*/cpu_rd_data1 follow their inputs combinationally.
- Push latency: a write at edge k makes tx_valid=1 after edge k, with tx_data = the written byte. There is no same-cycle bypass.
- Simultaneous push and pop:
  - When not full and not empty: both occur and count is unchanged.
  - When full: the pop frees a slot and the push is accepted; no overflow.
  - When empty: only the push occurs.
- tx_data and tx_valid must hold stable while tx_valid && !tx_ready.
- The STATUS read reflects state after the last edge (combinational from registers).
- Halt takes effect on the following cycle. The halt write itself reaches memory in the same cycle.
- Reset asserted mid-transfer: the FIFO contents are discarded, tx_valid drops asynchronously, and halted clears.
- The STATUS clear write and an overflowing push in the same cycle cannot occur, since there is only one write port.

## Test plan
- Pass-through: write 8'h10 to 8'h20 -> mem_wr_en=1, addr 8'h20, data 8'h10. Read 8'h20 via port 1 returns mem data unchanged.
- FIFO order: push 8'hA1, A2, A3 with tx_ready=0 -> STATUS = 8'h18 (count 3). Set tx_ready=1 -> tx_data sequence is A1, A2, A3, then tx_valid=0 and STATUS=8'h02.
- Overflow: push 5 bytes with tx_ready=0 (DEPTH=4) -> the 5th byte is dropped and STATUS=8'h25. Write 0 to 8'hF1 -> STATUS=8'h21. Drain yields only the first 4 bytes.
- Full with simultaneous push/pop: with FIFO full and tx_ready=1, push 8'h55 -> count stays 4, overflow stays 0, and 8'h55 emerges last.
- Halt: write 8'h01 to 8'hFF -> mem_wr_en=1 that cycle and halted=1 after the edge. A subsequent write to 8'h20 gives mem_wr_en=0. A queued byte still drains. Writing 8'h02 to 8'hFF does not halt.
- Async reset: assert reset between edges while the FIFO holds 2 bytes and halted=1 -> tx_valid=0 and halted=0 immediately. After release, STATUS=8'h02.
